mem_access_seq: RTL and testbench
=================================

Name: mem_access_seq

Overview:
- MEM-stage load/store sequencer for the dual-issue pipeline. It is the consumer end of the EXE/MEM pipeline register.
- Takes the registered inst1/inst2 memory fields and serializes up to two memory ops per bundle onto the single-port data bus, using a req/ack handshake.
- Raises a stall request while the bundle is in flight.
- Returns aligned, extended load data and address-error exceptions to the MEM/WB path.

Parameters:
- DATA_W, 32, data/address width; only 32 is supported.
- EXC_W, 5, exception code width; matches EXC_CODE_BUS.

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  synchronous reset, active-high: asserted when 1, sampled on posedge clk. The codebase port name is kept.
- flush  in  1  exception flush; kills the current bundle.
- stall  in  STALL_BUS  global stall bus; stall[4] set means MEM/WB is held.
- mem_inst1_memtype, mem_inst2_memtype  in  8  one-hot memory type: [0]LB [1]LBU [2]LH [3]LHU [4]LW [5]SB [6]SH [7]SW. All zero means not a memory op.
- mem_inst1_w2regdata, mem_inst2_w2regdata  in  32  effective address for memory ops.
- mem_inst1_w2ramdata, mem_inst2_w2ramdata  in  32  store data, right-justified.
- dreq  out  1  bus request.
- dwe  out  1  write enable.
- dsel  out  4  byte lane enables, little-endian.
- daddr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dwdata  out  32  lane-replicated store data.
- dack  in  1  bus acknowledge; completes the current request.
- drdata  in  32  read data, valid when dack=1.
- stallreq_mem  out  1  holds EXE/MEM and earlier stages.
- ld1_data, ld2_data  out  32  extended load results, registered.
- mem_exccode  out  EXC_W  EXC_NONE, ADEL (0x04) or ADES (0x05).
- mem_badvaddr  out  32  faulting address.

Behaviour:
- Reset: state IDLE; dreq=0, dwe=0, dsel=0, daddr=0, dwdata=0, ld1_data=0, ld2_data=0, mem_exccode=EXC_NONE, mem_badvaddr=0. stallreq_mem is 0 because state is IDLE with reset.
- Reset mid-operation: returns to IDLE immediately and drops dreq. Any in-flight bus beat is abandoned.
- FSM states: IDLE, OP1, OP2, ABORT, DONE.
- IDLE:
  - bundle = (memtype1|memtype2) != 0. With no bundle, the state stays IDLE.
  - Otherwise check alignment for inst1, then inst2. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - On the first fault: latch exccode (ADEL for loads, ADES for stores) and badvaddr, and go to DONE. No bus request is issued for the faulting op or any later op. An op before the fault still executes: OP1 runs first, then the fault is reported.
  - If inst1 is a memory op, go to OP1; otherwise go to OP2.
- OP1 / OP2:
  - dreq=1 with dwe/dsel/daddr/dwdata held stable until dack.
  - dsel: byte = 1<<addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
  - dwdata: byte is replicated x4; half is replicated x2.
  - On dack: capture the load result into ldN_data. Byte/half is selected by addr, then sign-extended (LB/LH) or zero-extended (LBU/LHU). Stores leave ldN_data unchanged.
  - After OP1: go to OP2 if inst2 is a memory op (and aligned), else DONE. After OP2: go to DONE.
  - dreq drops in the cycle after dack. At least one idle cycle separates back-to-back requests.
- stallreq_mem = 1 in IDLE when bundle is nonzero and resetn=0 and flush=0; also 1 in OP1, OP2 and ABORT. It is 0 in DONE.
- DONE:
  - Results and exccode are stable.
  - Go to IDLE when stall[4]==0; otherwise hold.
  - mem_exccode is cleared to EXC_NONE on leaving DONE.
- flush:
  - In IDLE: no request is issued.
  - In OP1/OP2: go to ABORT. The bus cannot cancel, so dreq stays high until dack; then go to IDLE. No results are written and exccode is not set.
  - In DONE: go to IDLE.
- Ordering: inst1 always completes before inst2 issues, so store→load to the same address within one bundle returns the stored value.

Decomposition:
- Shared package/defines:
  - memtype bit indices (MT_LB..MT_SW);
  - state encodings;
  - EXC_ADEL/EXC_ADES;
  - STALL_BUS index for MEM.
- One sub-module: mem_lane_fmt. It is combinational and produces dsel/dwdata from (memtype, addr, wdata) and the extended load value from (memtype, addr, drdata). It is instantiated twice, or shared via a mux on the active op.

Test Plan:
- Single LW: inst1 LW addr 0x100, dack at cycle 3 with drdata 0xDEADBEEF → daddr=0x100, dsel=4'b1111; ld1_data=0xDEADBEEF; stallreq high cycles 0–3, low in DONE.
- Dual SB+LBU to the same word: SB addr 0x203 data 0x5A, then LBU 0x203 → SB request: dsel=4'b1000, dwdata=0x5A5A5A5A. LBU issues only after the SB dack. With drdata=0x5A000000, ld2_data=0x0000005A.
- LH sign-extend: LH addr 0x302, drdata 0x8001_1234 → dsel=4'b1100, ld1_data=0xFFFF8001.
- Misaligned: inst1 LW 0x401 plus inst2 SW → no dreq; mem_exccode=0x04, badvaddr=0x401. Variant with inst1 SB ok and inst2 SW 0x402 → SB completes, then exccode=0x05, badvaddr=0x402.
- Flush during OP1 with dack delayed 4 cycles → dreq held until dack; then IDLE; ld1_data unchanged; exccode=EXC_NONE.
- Reset asserted during OP2 → next cycle dreq=0, stallreq_mem=0, all outputs at reset values.

Source files
------------

// File: rtl/mem_access_seq_pkg.sv
// Shared constants, state encoding and alignment helpers for the MEM-stage
// load/store sequencer.
package mem_access_seq_pkg;

    localparam int MT_LB  = 0;
    localparam int MT_LBU = 1;
    localparam int MT_LH  = 2;
    localparam int MT_LHU = 3;
    localparam int MT_LW  = 4;
    localparam int MT_SB  = 5;
    localparam int MT_SH  = 6;
    localparam int MT_SW  = 7;

    localparam int STALL_W   = 6;
    localparam int STALL_MEM = 4;

    // EXC_NONE sits outside the codes this stage can raise.
    localparam logic [4:0] EXC_NONE = 5'h1f;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OP1,
        ST_OP2,
        ST_ABORT,
        ST_DONE
    } state_e;

    function automatic logic is_store(input logic [7:0] mt);
        return mt[MT_SB] | mt[MT_SH] | mt[MT_SW];
    endfunction

    function automatic logic is_misaligned(input logic [7:0] mt, input logic [31:0] addr);
        return ((mt[MT_LH] | mt[MT_LHU] | mt[MT_SH]) & addr[0])
             | ((mt[MT_LW] | mt[MT_SW]) & (addr[1:0] != 2'b00));
    endfunction

    function automatic logic [4:0] fault_code(input logic [7:0] mt);
        return is_store(mt) ? EXC_ADES : EXC_ADEL;
    endfunction

endpackage

// File: rtl/mem_access_seq_lane_fmt.sv
// Byte-lane formatter: lane enables and replicated store data for a request,
// plus the selected and extended load value from the returned bus word.
module mem_lane_fmt
    import mem_access_seq_pkg::*;
(
    input  logic [7:0]  memtype_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        is_byte = memtype_i[MT_LB] | memtype_i[MT_LBU] | memtype_i[MT_SB];
        is_half = memtype_i[MT_LH] | memtype_i[MT_LHU] | memtype_i[MT_SH];
        is_word = memtype_i[MT_LW] | memtype_i[MT_SW];
        sel_o   = 4'b0000;
        wdata_o = wdata_i;
        ldata_o = rdata_i;

        case (addr_i[1:0])
            2'd0:    rbyte = rdata_i[7:0];
            2'd1:    rbyte = rdata_i[15:8];
            2'd2:    rbyte = rdata_i[23:16];
            default: rbyte = rdata_i[31:24];
        endcase
        rhalf = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        if (is_byte) begin
            sel_o   = 4'b0001 << addr_i[1:0];
            wdata_o = {4{wdata_i[7:0]}};
        end else if (is_half) begin
            sel_o   = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
        end else if (is_word) begin
            sel_o   = 4'b1111;
        end

        if (memtype_i[MT_LB])       ldata_o = {{24{rbyte[7]}}, rbyte};
        else if (memtype_i[MT_LBU]) ldata_o = {24'h0, rbyte};
        else if (memtype_i[MT_LH])  ldata_o = {{16{rhalf[15]}}, rhalf};
        else if (memtype_i[MT_LHU]) ldata_o = {16'h0, rhalf};
    end

endmodule

// File: rtl/mem_access_seq.sv
// MEM-stage sequencer: serializes up to two memory ops per bundle onto the
// single-port req/ack data bus and reports address-error exceptions.
module mem_access_seq
    import mem_access_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int EXC_W  = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic [STALL_W-1:0] stall,
    input  logic [7:0]         mem_inst1_memtype,
    input  logic [7:0]         mem_inst2_memtype,
    input  logic [DATA_W-1:0]  mem_inst1_w2regdata,
    input  logic [DATA_W-1:0]  mem_inst2_w2regdata,
    input  logic [DATA_W-1:0]  mem_inst1_w2ramdata,
    input  logic [DATA_W-1:0]  mem_inst2_w2ramdata,
    output logic               dreq,
    output logic               dwe,
    output logic [3:0]         dsel,
    output logic [DATA_W-1:0]  daddr,
    output logic [DATA_W-1:0]  dwdata,
    input  logic               dack,
    input  logic [DATA_W-1:0]  drdata,
    output logic               stallreq_mem,
    output logic [DATA_W-1:0]  ld1_data,
    output logic [DATA_W-1:0]  ld2_data,
    output logic [EXC_W-1:0]   mem_exccode,
    output logic [DATA_W-1:0]  mem_badvaddr
);

    state_e              state_q, state_d;
    logic                dreq_q, dreq_d, dwe_q, dwe_d;
    logic [3:0]          dsel_q, dsel_d;
    logic [DATA_W-1:0]   daddr_q, daddr_d, dwdata_q, dwdata_d;
    logic [DATA_W-1:0]   ld1_q, ld1_d, ld2_q, ld2_d, badv_q, badv_d;
    logic [EXC_W-1:0]    exc_q, exc_d;

    logic                mem1, mem2, bundle, mis1, mis2, op2_sel, issue, retire;
    logic [7:0]          op_mt;
    logic [DATA_W-1:0]   op_addr, op_wdata, fmt_wdata, fmt_ldata;
    logic [3:0]          fmt_sel;
    logic                unused_stall;

    assign unused_stall = ^{stall[STALL_W-1:STALL_MEM+1], stall[STALL_MEM-1:0]};

    assign mem1    = |mem_inst1_memtype;
    assign mem2    = |mem_inst2_memtype;
    assign bundle  = mem1 | mem2;
    assign mis1    = mem1 && is_misaligned(mem_inst1_memtype, mem_inst1_w2regdata);
    assign mis2    = mem2 && is_misaligned(mem_inst2_memtype, mem_inst2_w2regdata);

    // One formatter serves both ops; inst2 is active in OP2 or when IDLE skips inst1.
    assign op2_sel  = (state_q == ST_OP2) || (state_q == ST_IDLE && !mem1);
    assign op_mt    = op2_sel ? mem_inst2_memtype   : mem_inst1_memtype;
    assign op_addr  = op2_sel ? mem_inst2_w2regdata : mem_inst1_w2regdata;
    assign op_wdata = op2_sel ? mem_inst2_w2ramdata : mem_inst1_w2ramdata;

    mem_lane_fmt u_fmt (
        .memtype_i (op_mt),
        .addr_i    (op_addr),
        .wdata_i   (op_wdata),
        .rdata_i   (drdata),
        .sel_o     (fmt_sel),
        .wdata_o   (fmt_wdata),
        .ldata_o   (fmt_ldata)
    );

    always_comb begin
        state_d      = state_q;
        dreq_d       = dreq_q;
        dwe_d        = dwe_q;
        dsel_d       = dsel_q;
        daddr_d      = daddr_q;
        dwdata_d     = dwdata_q;
        ld1_d        = ld1_q;
        ld2_d        = ld2_q;
        exc_d        = exc_q;
        badv_d       = badv_q;
        issue        = 1'b0;
        retire       = 1'b0;
        stallreq_mem = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                stallreq_mem = bundle && !resetn && !flush;
                if (bundle && !flush) begin
                    if (mis1) begin
                        exc_d   = EXC_W'(fault_code(mem_inst1_memtype));
                        badv_d  = mem_inst1_w2regdata;
                        state_d = ST_DONE;
                    end else if (!mem1 && mis2) begin
                        exc_d   = EXC_W'(fault_code(mem_inst2_memtype));
                        badv_d  = mem_inst2_w2regdata;
                        state_d = ST_DONE;
                    end else begin
                        issue   = 1'b1;
                        state_d = mem1 ? ST_OP1 : ST_OP2;
                    end
                end
            end
            ST_OP1, ST_OP2: begin
                stallreq_mem = 1'b1;
                if (flush) begin
                    // The bus cannot cancel a beat, so an unacked request rides out in ABORT.
                    if (dreq_q && !dack) begin
                        state_d = ST_ABORT;
                    end else begin
                        retire  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (!dreq_q) begin
                    issue = 1'b1;
                end else if (dack) begin
                    retire = 1'b1;
                    if (state_q == ST_OP1) begin
                        if (!is_store(op_mt)) ld1_d = fmt_ldata;
                        if (mis2) begin
                            exc_d   = EXC_W'(fault_code(mem_inst2_memtype));
                            badv_d  = mem_inst2_w2regdata;
                            state_d = ST_DONE;
                        end else begin
                            state_d = mem2 ? ST_OP2 : ST_DONE;
                        end
                    end else begin
                        if (!is_store(op_mt)) ld2_d = fmt_ldata;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ABORT: begin
                stallreq_mem = 1'b1;
                if (dack) begin
                    retire  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (flush || !stall[STALL_MEM]) begin
                    exc_d   = EXC_W'(EXC_NONE);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            dreq_d   = 1'b1;
            dwe_d    = is_store(op_mt);
            dsel_d   = fmt_sel;
            daddr_d  = {op_addr[DATA_W-1:2], 2'b00};
            dwdata_d = fmt_wdata;
        end
        if (retire) begin
            dreq_d = 1'b0;
            dwe_d  = 1'b0;
            dsel_d = 4'b0000;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q  <= ST_IDLE;
            dreq_q   <= 1'b0;
            dwe_q    <= 1'b0;
            dsel_q   <= 4'b0000;
            daddr_q  <= '0;
            dwdata_q <= '0;
            ld1_q    <= '0;
            ld2_q    <= '0;
            exc_q    <= EXC_W'(EXC_NONE);
            badv_q   <= '0;
        end else begin
            state_q  <= state_d;
            dreq_q   <= dreq_d;
            dwe_q    <= dwe_d;
            dsel_q   <= dsel_d;
            daddr_q  <= daddr_d;
            dwdata_q <= dwdata_d;
            ld1_q    <= ld1_d;
            ld2_q    <= ld2_d;
            exc_q    <= exc_d;
            badv_q   <= badv_d;
        end
    end

    assign dreq         = dreq_q;
    assign dwe          = dwe_q;
    assign dsel         = dsel_q;
    assign daddr        = daddr_q;
    assign dwdata       = dwdata_q;
    assign ld1_data     = ld1_q;
    assign ld2_data     = ld2_q;
    assign mem_exccode  = exc_q;
    assign mem_badvaddr = badv_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: each task drives one scenario and checks
// bus and result outputs one time unit after the rising edge.
module tb_mem_access_seq;
    import mem_access_seq_pkg::*;

    localparam logic [7:0] T_LB  = 8'h01;
    localparam logic [7:0] T_LBU = 8'h02;
    localparam logic [7:0] T_LH  = 8'h04;
    localparam logic [7:0] T_LW  = 8'h10;
    localparam logic [7:0] T_SB  = 8'h20;
    localparam logic [7:0] T_SW  = 8'h80;

    logic               clk = 1'b0;
    logic               resetn, flush, dack;
    logic [STALL_W-1:0] stall;
    logic [7:0]         mt1, mt2;
    logic [31:0]        a1, a2, wd1, wd2, drdata;
    logic               dreq, dwe, stallreq_mem;
    logic [3:0]         dsel;
    logic [31:0]        daddr, dwdata, ld1_data, ld2_data, mem_badvaddr;
    logic [4:0]         mem_exccode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_seq dut (
        .clk                 (clk),
        .resetn              (resetn),
        .flush               (flush),
        .stall               (stall),
        .mem_inst1_memtype   (mt1),
        .mem_inst2_memtype   (mt2),
        .mem_inst1_w2regdata (a1),
        .mem_inst2_w2regdata (a2),
        .mem_inst1_w2ramdata (wd1),
        .mem_inst2_w2ramdata (wd2),
        .dreq                (dreq),
        .dwe                 (dwe),
        .dsel                (dsel),
        .daddr               (daddr),
        .dwdata              (dwdata),
        .dack                (dack),
        .drdata              (drdata),
        .stallreq_mem        (stallreq_mem),
        .ld1_data            (ld1_data),
        .ld2_data            (ld2_data),
        .mem_exccode         (mem_exccode),
        .mem_badvaddr        (mem_badvaddr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [7:0] t1, input logic [31:0] ad1, input logic [31:0] d1,
                              input logic [7:0] t2, input logic [31:0] ad2, input logic [31:0] d2);
        mt1 = t1; a1 = ad1; wd1 = d1;
        mt2 = t2; a2 = ad2; wd2 = d2;
    endtask

    task automatic test_reset();
        resetn = 1'b1; flush = 1'b0; stall = '0; dack = 1'b0; drdata = '0;
        set_bundle(8'h00, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0);
        tick(); tick();
        checks++; if ({dreq, dwe, dsel} !== 6'b0) begin errors++; $display("FAIL reset_bus got %b want 000000", {dreq, dwe, dsel}); end
        checks++; if ({daddr, dwdata} !== 64'h0) begin errors++; $display("FAIL reset_addr_data got %h want 0", {daddr, dwdata}); end
        checks++; if ({ld1_data, ld2_data} !== 64'h0) begin errors++; $display("FAIL reset_ld got %h want 0", {ld1_data, ld2_data}); end
        checks++; if (mem_exccode !== EXC_NONE) begin errors++; $display("FAIL reset_exc got %h want %h", mem_exccode, EXC_NONE); end
        checks++; if (mem_badvaddr !== 32'h0) begin errors++; $display("FAIL reset_badv got %h want 0", mem_badvaddr); end
        set_bundle(T_LW, 32'h100, 32'h0, 8'h00, 32'h0, 32'h0);
        #1;
        checks++; if (stallreq_mem !== 1'b0) begin errors++; $display("FAIL reset_stallreq got %b want 0", stallreq_mem); end
        tick();
        checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL reset_noreq got %b want 0", dreq); end
        resetn = 1'b0;
        set_bundle(8'h00, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_single_lw();
        set_bundle(T_LW, 32'h100, 32'h0, 8'h00, 32'h0, 32'h0);
        #1;
        checks++; if ({stallreq_mem, dreq} !== 2'b10) begin errors++; $display("FAIL lw_c0 stallreq/dreq got %b want 10", {stallreq_mem, dreq}); end
        tick();
        checks++; if ({dreq, dwe, dsel} !== 6'b10_1111) begin errors++; $display("FAIL lw_req got %b want 101111", {dreq, dwe, dsel}); end
        checks++; if (daddr !== 32'h100) begin errors++; $display("FAIL lw_daddr got %h want 00000100", daddr); end
        tick();
        checks++; if ({stallreq_mem, dreq} !== 2'b11) begin errors++; $display("FAIL lw_c2 got %b want 11", {stallreq_mem, dreq}); end
        tick();
        dack = 1'b1; drdata = 32'hDEADBEEF;
        checks++; if ({stallreq_mem, dreq} !== 2'b11) begin errors++; $display("FAIL lw_c3 got %b want 11", {stallreq_mem, dreq}); end
        tick();
        dack = 1'b0;
        checks++; if (ld1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_ld1 got %h want deadbeef", ld1_data); end
        checks++; if ({stallreq_mem, dreq} !== 2'b00) begin errors++; $display("FAIL lw_done got %b want 00", {stallreq_mem, dreq}); end
        checks++; if (mem_exccode !== EXC_NONE) begin errors++; $display("FAIL lw_exc got %h want %h", mem_exccode, EXC_NONE); end
        set_bundle(8'h00, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_back_to_back();
        set_bundle(T_SB, 32'h203, 32'h5A, T_LBU, 32'h203, 32'h0);
        tick();
        checks++; if ({dreq, dwe, dsel} !== 6'b11_1000) begin errors++; $display("FAIL sb_req got %b want 111000", {dreq, dwe, dsel}); end
        checks++; if (dwdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL sb_wdata got %h want 5a5a5a5a", dwdata); end
        checks++; if (daddr !== 32'h200) begin errors++; $display("FAIL sb_daddr got %h want 00000200", daddr); end
        dack = 1'b1;
        tick();
        dack = 1'b0;
        checks++; if ({stallreq_mem, dreq} !== 2'b10) begin errors++; $display("FAIL b2b_gap got %b want 10", {stallreq_mem, dreq}); end
        tick();
        checks++; if ({dreq, dwe, dsel} !== 6'b10_1000) begin errors++; $display("FAIL lbu_req got %b want 101000", {dreq, dwe, dsel}); end
        dack = 1'b1; drdata = 32'h5A000000;
        tick();
        dack = 1'b0;
        checks++; if (ld2_data !== 32'h0000005A) begin errors++; $display("FAIL lbu_ld2 got %h want 0000005a", ld2_data); end
        checks++; if (ld1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sb_ld1_kept got %h want deadbeef", ld1_data); end
        set_bundle(8'h00, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_sign_extend();
        set_bundle(T_LH, 32'h302, 32'h0, T_LB, 32'h301, 32'h0);
        tick();
        checks++; if ({dreq, dwe, dsel} !== 6'b10_1100) begin errors++; $display("FAIL lh_req got %b want 101100", {dreq, dwe, dsel}); end
        dack = 1'b1; drdata = 32'h80011234;
        tick();
        dack = 1'b0;
        checks++; if (ld1_data !== 32'hFFFF8001) begin errors++; $display("FAIL lh_ld1 got %h want ffff8001", ld1_data); end
        tick();
        checks++; if ({dreq, dsel} !== 5'b1_0010) begin errors++; $display("FAIL lb_req got %b want 10010", {dreq, dsel}); end
        dack = 1'b1; drdata = 32'h00008000;
        tick();
        dack = 1'b0;
        checks++; if (ld2_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_ld2 got %h want ffffff80", ld2_data); end
        set_bundle(8'h00, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_misaligned();
        set_bundle(T_LW, 32'h401, 32'h0, T_SW, 32'h500, 32'h1234);
        #1;
        checks++; if ({stallreq_mem, dreq} !== 2'b10) begin errors++; $display("FAIL adel_c0 got %b want 10", {stallreq_mem, dreq}); end
        tick();
        checks++; if ({stallreq_mem, dreq} !== 2'b00) begin errors++; $display("FAIL adel_noreq got %b want 00", {stallreq_mem, dreq}); end
        checks++; if (mem_exccode !== 5'h04) begin errors++; $display("FAIL adel_exc got %h want 04", mem_exccode); end
        checks++; if (mem_badvaddr !== 32'h401) begin errors++; $display("FAIL adel_badv got %h want 00000401", mem_badvaddr); end
        stall[STALL_MEM] = 1'b1;
        set_bundle(8'h00, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0);
        tick();
        checks++; if (mem_exccode !== 5'h04) begin errors++; $display("FAIL done_hold_exc got %h want 04", mem_exccode); end
        stall = '0;
        tick();
        checks++; if (mem_exccode !== EXC_NONE) begin errors++; $display("FAIL done_clear_exc got %h want %h", mem_exccode, EXC_NONE); end

        set_bundle(T_SB, 32'h600, 32'h11, T_SW, 32'h402, 32'h0);
        tick();
        checks++; if ({dreq, dwe, dsel} !== 6'b11_0001) begin errors++; $display("FAIL ades_sb_req got %b want 110001", {dreq, dwe, dsel}); end
        checks++; if (dwdata !== 32'h11111111) begin errors++; $display("FAIL ades_sb_wdata got %h want 11111111", dwdata); end
        checks++; if (mem_exccode !== EXC_NONE) begin errors++; $display("FAIL ades_early_exc got %h want %h", mem_exccode, EXC_NONE); end
        dack = 1'b1;
        tick();
        dack = 1'b0;
        checks++; if (mem_exccode !== 5'h05) begin errors++; $display("FAIL ades_exc got %h want 05", mem_exccode); end
        checks++; if (mem_badvaddr !== 32'h402) begin errors++; $display("FAIL ades_badv got %h want 00000402", mem_badvaddr); end
        checks++; if ({stallreq_mem, dreq} !== 2'b00) begin errors++; $display("FAIL ades_noreq got %b want 00", {stallreq_mem, dreq}); end
        set_bundle(8'h00, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_flush();
        set_bundle(T_LW, 32'h700, 32'h0, 8'h00, 32'h0, 32'h0);
        tick();
        checks++; if (dreq !== 1'b1) begin errors++; $display("FAIL flush_req got %b want 1", dreq); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_bundle(8'h00, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++; if ({stallreq_mem, dreq} !== 2'b11) begin errors++; $display("FAIL abort_hold%0d got %b want 11", i, {stallreq_mem, dreq}); end
            tick();
        end
        dack = 1'b1; drdata = 32'hBAD0BAD0;
        tick();
        dack = 1'b0;
        checks++; if ({stallreq_mem, dreq} !== 2'b00) begin errors++; $display("FAIL abort_end got %b want 00", {stallreq_mem, dreq}); end
        checks++; if (ld1_data !== 32'hFFFF8001) begin errors++; $display("FAIL abort_ld1 got %h want ffff8001", ld1_data); end
        checks++; if (mem_exccode !== EXC_NONE) begin errors++; $display("FAIL abort_exc got %h want %h", mem_exccode, EXC_NONE); end
        tick();
        checks++; if (dreq !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", dreq); end
    endtask

    task automatic test_reset_mid_op();
        set_bundle(T_SW, 32'h800, 32'hCAFEF00D, T_LW, 32'h804, 32'h0);
        tick();
        dack = 1'b1;
        tick();
        dack = 1'b0;
        tick();
        checks++; if ({dreq, dwe, dsel, daddr} !== {6'b10_1111, 32'h804}) begin errors++; $display("FAIL op2_req got %b/%h want 101111/00000804", {dreq, dwe, dsel}, daddr); end
        resetn = 1'b1;
        tick();
        checks++; if ({dreq, dwe, dsel, stallreq_mem} !== 7'b0) begin errors++; $display("FAIL rst_mid_bus got %b want 0000000", {dreq, dwe, dsel, stallreq_mem}); end
        checks++; if ({daddr, dwdata} !== 64'h0) begin errors++; $display("FAIL rst_mid_addr got %h want 0", {daddr, dwdata}); end
        checks++; if ({ld1_data, ld2_data, mem_badvaddr} !== 96'h0) begin errors++; $display("FAIL rst_mid_regs got %h want 0", {ld1_data, ld2_data, mem_badvaddr}); end
        checks++; if (mem_exccode !== EXC_NONE) begin errors++; $display("FAIL rst_mid_exc got %h want %h", mem_exccode, EXC_NONE); end
        resetn = 1'b0;
        set_bundle(8'h00, 32'h0, 32'h0, 8'h00, 32'h0, 32'h0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_lw();
        test_back_to_back();
        test_sign_extend();
        test_misaligned();
        test_flush();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
